// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the HH:MM time-setting front end: FSM encoding,
// BCD field limits and display digit masks.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

  localparam logic [3:0] MASK_HR   = 4'b1100;
  localparam logic [3:0] MASK_MIN  = 4'b0011;
  localparam logic [3:0] MASK_NONE = 4'b0000;

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce
// counter and a one-cycle pulse on each accepted 0->1 change.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic CRbar,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // The count only advances while the synchronized input disagrees with the
  // accepted level; any agreement (a bounce back) restarts it from zero.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge CRbar) begin
    if (!CRbar) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting edit controller: captures the running time, steps hours and
// minutes in BCD, and commits the result with a one-cycle load strobe.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_RUN     | clock counts, display shows cur_time, inc ignored
//   ST_SET_HR  | inc steps hour 00..23, hour digits blink
//   ST_SET_MIN | inc steps minute 00..59, minute digits blink; mode commits
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        CRbar,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [15:0] cur_time,
  output logic [15:0] set_time,
  output logic        load,
  output logic        running,
  output logic        disp_sel,
  output logic [3:0]  blink_mask
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic mode_p, inc_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_mode (
    .clk     (clk),
    .CRbar   (CRbar),
    .btn_raw (btn_mode),
    .press   (mode_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_inc (
    .clk     (clk),
    .CRbar   (CRbar),
    .btn_raw (btn_inc),
    .press   (inc_p)
  );

  // Any malformed field (bad digit or out of range) recovers to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                         input logic [7:0] max_val);
    logic [7:0] r;
    r = 8'h00;
    if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val >= max_val)) begin
      r = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      r = {val[7:4] + 4'd1, 4'd0};
    end else begin
      r = {val[7:4], val[3:0] + 4'd1};
    end
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [15:0]    set_time_q, set_time_d;
  logic           load_q, load_d;
  logic           phase_q, phase_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;

  always_comb begin
    state_d    = state_q;
    set_time_d = set_time_q;
    load_d     = 1'b0;
    phase_d    = phase_q;
    bcnt_d     = bcnt_q;

    if (state_q != ST_RUN) begin
      if (bcnt_q == '0) begin
        phase_d = ~phase_q;
        bcnt_d  = BLINK_LAST;
      end else begin
        bcnt_d = bcnt_q - BW'(1);
      end
    end

    // Mode has priority; a coincident inc pulse is dropped.
    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          set_time_d = cur_time;
          state_d    = ST_SET_HR;
          phase_d    = 1'b0;
          bcnt_d     = BLINK_LAST;
        end
      end
      ST_SET_HR: begin
        if (mode_p) begin
          state_d = ST_SET_MIN;
        end else if (inc_p) begin
          set_time_d[15:8] = bcd_inc(set_time_q[15:8], HR_MAX);
        end
      end
      ST_SET_MIN: begin
        if (mode_p) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (inc_p) begin
          set_time_d[7:0] = bcd_inc(set_time_q[7:0], MIN_MAX);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge CRbar) begin
    if (!CRbar) begin
      state_q    <= ST_RUN;
      set_time_q <= 16'h0000;
      load_q     <= 1'b0;
      phase_q    <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      set_time_q <= set_time_d;
      load_q     <= load_d;
      phase_q    <= phase_d;
      bcnt_q     <= bcnt_d;
    end
  end

  always_comb begin
    blink_mask = MASK_NONE;
    case (state_q)
      ST_SET_HR:  blink_mask = MASK_HR  & {4{phase_q}};
      ST_SET_MIN: blink_mask = MASK_MIN & {4{phase_q}};
      default:    blink_mask = MASK_NONE;
    endcase
  end

  assign running  = (state_q == ST_RUN);
  assign disp_sel = ~running;
  assign set_time = set_time_q;
  assign load     = load_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with short debounce/blink periods;
// committed values are checked through a load scoreboard.
module tb_clock_set_ctrl;
  import clock_set_ctrl_pkg::*;

  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic        clk;
  logic        CRbar;
  logic        btn_mode;
  logic        btn_inc;
  logic [15:0] cur_time;
  logic [15:0] set_time;
  logic        load;
  logic        running;
  logic        disp_sel;
  logic [3:0]  blink_mask;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic        load_prev = 1'b0;

  clock_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
    .clk        (clk),
    .CRbar      (CRbar),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_time   (cur_time),
    .set_time   (set_time),
    .load       (load),
    .running    (running),
    .disp_sel   (disp_sel),
    .blink_mask (blink_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load scoreboard: every strobe must match the next expected commit value.
  always @(negedge clk) begin
    if (CRbar && load) begin
      checks++;
      if (load_prev) begin
        errors++;
        $display("FAIL load_width: load high two cycles in a row, required one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: set_time=%h, required no load", set_time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (set_time !== e) begin
          errors++;
          $display("FAIL load_value: set_time=%h required %h", set_time, e);
        end
      end
    end
    load_prev = load;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the button long enough for one pulse plus the registered update,
  // then releases and waits for the release to be accepted.
  task automatic press(input logic is_mode);
    if (is_mode) btn_mode = 1'b1;
    else         btn_inc  = 1'b1;
    step(DEB + 3);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(DEB + 4);
  endtask

  task automatic test_reset;
    CRbar = 1'b0;
    #1;
    checks++;
    if ({running, disp_sel, load, blink_mask, set_time} !== {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_outputs: run=%b sel=%b load=%b mask=%b set=%h, required 1 0 0 0000 0000",
               running, disp_sel, load, blink_mask, set_time);
    end
    step(3);
    CRbar = 1'b1;
    step(2);
    checks++;
    if (running !== 1'b1 || set_time !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: run=%b set=%h, required 1 0000", running, set_time);
    end
  endtask

  task automatic test_capture_wrap;
    cur_time = 16'h2259;
    press(1'b1);
    checks++;
    if (set_time !== 16'h2259 || running !== 1'b0 || disp_sel !== 1'b1) begin
      errors++;
      $display("FAIL capture: set=%h run=%b sel=%b, required 2259 0 1", set_time, running, disp_sel);
    end
    press(1'b0);
    checks++;
    if (set_time !== 16'h2359) begin
      errors++;
      $display("FAIL hour_inc: set=%h required 2359", set_time);
    end
    press(1'b0);
    checks++;
    if (set_time !== 16'h0059) begin
      errors++;
      $display("FAIL hour_wrap: set=%h required 0059", set_time);
    end
    press(1'b1);
    exp_q.push_back(16'h0059);
    press(1'b1);
    checks++;
    if (running !== 1'b1 || disp_sel !== 1'b0 || blink_mask !== 4'h0) begin
      errors++;
      $display("FAIL commit_state: run=%b sel=%b mask=%b, required 1 0 0000", running, disp_sel, blink_mask);
    end
    cur_time = 16'h0101;
    step(3);
    checks++;
    if (set_time !== 16'h0059) begin
      errors++;
      $display("FAIL run_hold: set=%h required 0059", set_time);
    end
  endtask

  // Bounce in RUN: one pulse expected, and inc must not alter set_time.
  task automatic test_debounce;
    int pulses;
    int first_k;
    pulses  = 0;
    first_k = -1;
    btn_inc = 1'b1; step(1);
    btn_inc = 1'b0; step(1);
    btn_inc = 1'b1; step(1);
    btn_inc = 1'b0; step(1);
    btn_inc = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (dut.u_db_inc.press === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k == 10) btn_inc = 1'b0;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL deb_count: pulses=%0d required 1", pulses);
    end
    checks++;
    if (first_k != DEB + 2) begin
      errors++;
      $display("FAIL deb_latency: cycle=%0d required %0d", first_k, DEB + 2);
    end
    checks++;
    if (set_time !== 16'h0059 || running !== 1'b1) begin
      errors++;
      $display("FAIL inc_in_run: set=%h run=%b, required 0059 1", set_time, running);
    end
  endtask

  task automatic test_minute;
    logic [15:0] e;
    cur_time = 16'h1009;
    press(1'b1);
    press(1'b1);
    for (int m = 10; m <= 59; m++) begin
      press(1'b0);
      e = {8'h10, 4'(m / 10), 4'(m % 10)};
      checks++;
      if (set_time !== e) begin
        errors++;
        $display("FAIL min_step: set=%h required %h", set_time, e);
      end
    end
    press(1'b0);
    checks++;
    if (set_time !== 16'h1000) begin
      errors++;
      $display("FAIL min_wrap: set=%h required 1000", set_time);
    end
    exp_q.push_back(16'h1000);
    press(1'b1);
  endtask

  task automatic test_invalid;
    cur_time = 16'h2A5F;
    press(1'b1);
    press(1'b0);
    checks++;
    if (set_time !== 16'h005F) begin
      errors++;
      $display("FAIL bad_hour: set=%h required 005F", set_time);
    end
    press(1'b1);
    press(1'b0);
    checks++;
    if (set_time !== 16'h0000) begin
      errors++;
      $display("FAIL bad_min: set=%h required 0000", set_time);
    end
    exp_q.push_back(16'h0000);
    press(1'b1);
  endtask

  task automatic test_simultaneous;
    cur_time = 16'h0830;
    press(1'b1);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(DEB + 3);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(DEB + 4);
    checks++;
    if (dut.state_q !== ST_SET_MIN || set_time !== 16'h0830) begin
      errors++;
      $display("FAIL simul: state=%0d set=%h, required %0d 0830", dut.state_q, set_time, ST_SET_MIN);
    end
    press(1'b0);
    checks++;
    if (set_time !== 16'h0831) begin
      errors++;
      $display("FAIL simul_min: set=%h required 0831", set_time);
    end
    exp_q.push_back(16'h0831);
    press(1'b1);
  endtask

  task automatic test_blink;
    logic [3:0] e;
    logic       ph;
    cur_time = 16'h1234;
    btn_mode = 1'b1;
    step(DEB + 3);
    // Cycle i counts edges since entry to SET_HR; second mode press lands at 47.
    for (int i = 0; i < 80; i++) begin
      ph = ((i / BLINK) % 2) == 1;
      e  = (i < 47) ? (4'b1100 & {4{ph}}) : (4'b0011 & {4{ph}});
      checks++;
      if (blink_mask !== e) begin
        errors++;
        $display("FAIL blink: cycle=%0d mask=%b required %b", i, blink_mask, e);
      end
      if (i == 20 || i == 60) btn_mode = 1'b0;
      if (i == 40)            btn_mode = 1'b1;
      step(1);
    end
    exp_q.push_back(16'h1234);
    press(1'b1);
    checks++;
    if (blink_mask !== 4'h0 || running !== 1'b1) begin
      errors++;
      $display("FAIL blink_after_commit: mask=%b run=%b, required 0000 1", blink_mask, running);
    end
  endtask

  task automatic test_reset_mid_edit;
    cur_time = 16'h1545;
    press(1'b1);
    press(1'b1);
    press(1'b0);
    checks++;
    if (set_time !== 16'h1546 || running !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_edit: set=%h run=%b, required 1546 0", set_time, running);
    end
    CRbar = 1'b0;
    #1;
    checks++;
    if ({running, disp_sel, load, blink_mask, set_time} !== {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000}) begin
      errors++;
      $display("FAIL mid_reset: run=%b sel=%b load=%b mask=%b set=%h, required 1 0 0 0000 0000",
               running, disp_sel, load, blink_mask, set_time);
    end
    step(2);
    CRbar = 1'b1;
    step(DEB + 4);
    checks++;
    if (dut.state_q !== ST_RUN || set_time !== 16'h0000 || blink_mask !== 4'h0) begin
      errors++;
      $display("FAIL post_reset: state=%0d set=%h mask=%b, required 0 0000 0000",
               dut.state_q, set_time, blink_mask);
    end
  endtask

  initial begin
    CRbar    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cur_time = 16'h0000;
    test_reset();
    test_capture_wrap();
    test_debounce();
    test_minute();
    test_invalid();
    test_simultaneous();
    test_blink();
    test_reset_mid_edit();
    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_load: pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
